// File: rtl/ldtu_ser_lane_rx.sv
// Single-lane receiver for one LiTE-DTU serializer output: hunts the sync word,
// confirms word alignment over LOCK_COUNT boundaries, then delivers aligned words.
`timescale 1ns/1ps

module ldtu_ser_lane_rx #(
    parameter logic [31:0] SYNC_WORD  = 32'hEAAAAAAA,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        CLK_SRL,
    input  logic        RST,
    input  logic        SER_IN,
    input  logic        RESYNC,
    output logic [31:0] DATA_OUT,
    output logic        DATA_VALID,
    output logic        IDLE_SEEN,
    output logic        LOCKED,
    output logic [15:0] WORD_CNT
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

    state_e      state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [31:0] data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        idle_seen_q, idle_seen_d;
    logic        locked_q, locked_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    logic sync_match;
    logic boundary;

    assign sync_match = (sr_q == SYNC_WORD);
    assign boundary   = (bcnt_q == 5'd0);

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
        state_d      = state_q;
        sr_d         = {sr_q[30:0], SER_IN};
        bcnt_d       = bcnt_q;
        scnt_d       = scnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        idle_seen_d  = 1'b0;
        word_cnt_d   = word_cnt_q;

        if (RESYNC) begin
            // Resync wins over a coincident boundary; data and count are held.
            state_d = ST_HUNT;
            scnt_d  = 4'd0;
            bcnt_d  = 5'd0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    bcnt_d = 5'd0;
                    if (sync_match) begin
                        bcnt_d = 5'd1;
                        if (LOCK_CNT4 == 4'd1) begin
                            state_d    = ST_LOCKED;
                            word_cnt_d = 16'd0;
                        end else begin
                            state_d = ST_CONFIRM;
                            scnt_d  = 4'd1;
                        end
                    end
                end

                ST_CONFIRM: begin
                    bcnt_d = bcnt_q + 5'd1;
                    if (boundary) begin
                        if (sync_match) begin
                            scnt_d = scnt_q + 4'd1;
                            if (scnt_q + 4'd1 == LOCK_CNT4) begin
                                state_d    = ST_LOCKED;
                                word_cnt_d = 16'd0;
                            end
                        end else begin
                            state_d = ST_HUNT;
                            scnt_d  = 4'd0;
                            bcnt_d  = 5'd0;
                        end
                    end
                end

                ST_LOCKED: begin
                    bcnt_d = bcnt_q + 5'd1;
                    // Payload may mimic the sync word, so alignment is never re-checked here.
                    if (boundary) begin
                        if (sync_match) begin
                            idle_seen_d = 1'b1;
                        end else begin
                            data_out_d   = sr_q;
                            data_valid_d = 1'b1;
                            if (word_cnt_q != 16'hFFFF) begin
                                word_cnt_d = word_cnt_q + 16'd1;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    scnt_d  = 4'd0;
                    bcnt_d  = 5'd0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge CLK_SRL) begin
        if (RST) begin
            state_q      <= ST_HUNT;
            sr_q         <= 32'd0;
            bcnt_q       <= 5'd0;
            scnt_q       <= 4'd0;
            data_out_q   <= 32'd0;
            data_valid_q <= 1'b0;
            idle_seen_q  <= 1'b0;
            locked_q     <= 1'b0;
            word_cnt_q   <= 16'd0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q      <= state_d;
            sr_q         <= sr_d;
            bcnt_q       <= bcnt_d;
            scnt_q       <= scnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            idle_seen_q  <= idle_seen_d;
            locked_q     <= locked_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign DATA_OUT   = data_out_q;
    assign DATA_VALID = data_valid_q;
    assign IDLE_SEEN  = idle_seen_q;
    assign LOCKED     = locked_q;
    assign WORD_CNT   = word_cnt_q;

    // Output pulses are exclusive and only ever issued while locked.
    a_pulse_excl : assert property (@(posedge CLK_SRL) disable iff (RST)
        !(DATA_VALID && IDLE_SEEN));
    a_pulse_locked : assert property (@(posedge CLK_SRL) disable iff (RST)
        (DATA_VALID || IDLE_SEEN) |-> LOCKED);

endmodule
